// File: rtl/pdm_sd_modulator_tx_if.sv
// PCM sample stream into the PDM transmitter.
// Handshake: a sample transfers on every rising clk edge where pcm_valid and
// pcm_ready are both high. The source holds pcm_in stable while pcm_valid is
// high. pcm_ready does not depend on pcm_valid in the same cycle.
interface pdm_sd_modulator_tx_if;
  logic signed [15:0] pcm_in;
  logic               pcm_valid;
  logic               pcm_ready;

  modport master (output pcm_in, output pcm_valid, input pcm_ready);
  modport slave  (input pcm_in, input pcm_valid, output pcm_ready);
endinterface

// File: rtl/pdm_sd_modulator_tx.sv
// PCM-to-PDM transmitter: programmable PDM clock divider, one-entry sample
// buffer with zero-order hold, and a second-order sigma-delta modulator.
module pdm_sd_modulator_tx #(
  parameter int OSR       = 64,
  parameter int ACC_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [7:0]              clk_div,
  input  logic [2:0]              gain_shift,
  pdm_sd_modulator_tx_if.slave    pcm,
  output logic                    pdm_clk,
  output logic                    pdm_out,
  output logic                    sample_strobe,
  output logic                    underflow
);

  localparam int BIT_W = $clog2(OSR);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(OSR - 1);

  // Integrator clamp limits and feedback levels, in the widened sum domain.
  localparam logic signed [ACC_WIDTH+1:0] SAT_MAX = (ACC_WIDTH+2)'((longint'(1) <<< (ACC_WIDTH-2)) - 1);
  localparam logic signed [ACC_WIDTH+1:0] SAT_MIN = (ACC_WIDTH+2)'(-(longint'(1) <<< (ACC_WIDTH-2)));
  localparam logic signed [ACC_WIDTH+1:0] FB_POS  = (ACC_WIDTH+2)'(32768);
  localparam logic signed [ACC_WIDTH+1:0] FB_NEG  = (ACC_WIDTH+2)'(-32768);

  logic [7:0]                  div_cnt;
  logic [7:0]                  div_lim;
  logic                        div_term;
  logic                        step;
  logic                        load;
  logic                        hs;
  logic [BIT_W-1:0]            bit_cnt;
  logic signed [15:0]          cur_smp;
  logic signed [15:0]          buf_smp;
  logic                        buf_full;
  logic signed [ACC_WIDTH-1:0] acc1;
  logic signed [ACC_WIDTH-1:0] acc2;
  logic signed [15:0]          x_sh;
  logic signed [ACC_WIDTH+1:0] x_ext;
  logic signed [ACC_WIDTH+1:0] fb;
  logic signed [ACC_WIDTH+1:0] fb2;
  logic signed [ACC_WIDTH+1:0] acc1_ext;
  logic signed [ACC_WIDTH+1:0] acc2_ext;
  logic signed [ACC_WIDTH+1:0] sum1;
  logic signed [ACC_WIDTH+1:0] sum2;
  logic signed [ACC_WIDTH-1:0] a1;
  logic signed [ACC_WIDTH-1:0] a2;
  logic signed [ACC_WIDTH+1:0] a1_ext;

  function automatic logic signed [ACC_WIDTH-1:0] sat(input logic signed [ACC_WIDTH+1:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[ACC_WIDTH-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[ACC_WIDTH-1:0];
    else                  sat = v[ACC_WIDTH-1:0];
  endfunction

  // div_lim shadows clk_div and is only refreshed at terminal count, so a
  // new divider value never truncates or stretches the phase in progress.
  assign div_term = (div_cnt == div_lim);
  assign step     = enable & div_term & ~pdm_clk;
  assign load     = step & (bit_cnt == LAST_BIT);

  assign pcm.pcm_ready = enable & ~buf_full & ~rst;
  assign hs            = pcm.pcm_valid & pcm.pcm_ready;

  // Datapath for one modulator step.
  assign x_sh     = cur_smp >>> gain_shift;
  assign x_ext    = {{(ACC_WIDTH+2-16){x_sh[15]}}, x_sh};
  assign fb       = pdm_out ? FB_POS : FB_NEG;
  assign fb2      = pdm_out ? (FB_POS <<< 1) : (FB_NEG <<< 1);
  assign acc1_ext = {{2{acc1[ACC_WIDTH-1]}}, acc1};
  assign acc2_ext = {{2{acc2[ACC_WIDTH-1]}}, acc2};
  assign sum1     = acc1_ext + x_ext - fb;
  assign a1       = sat(sum1);
  assign a1_ext   = {{2{a1[ACC_WIDTH-1]}}, a1};
  assign sum2     = acc2_ext + a1_ext - fb2;
  assign a2       = sat(sum2);

  // PDM clock divider: toggle pdm_clk each time div_cnt reaches div_lim.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      div_lim <= '0;
      pdm_clk <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      div_lim <= clk_div;
      pdm_clk <= 1'b0;
    end else if (div_term) begin
      div_cnt <= '0;
      div_lim <= clk_div;
      pdm_clk <= ~pdm_clk;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // Sigma-delta integrators and output bit, advanced on each pdm_clk rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc1    <= '0;
      acc2    <= '0;
      pdm_out <= 1'b0;
    end else if (!enable) begin
      acc1    <= '0;
      acc2    <= '0;
      pdm_out <= 1'b0;
    end else if (step) begin
      acc1    <= a1;
      acc2    <= a2;
      pdm_out <= ~a2[ACC_WIDTH-1];
    end
  end

  // Bit counter, sample buffer and load-event handling (buffer, bypass, hold).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt       <= '0;
      cur_smp       <= '0;
      buf_smp       <= '0;
      buf_full      <= 1'b0;
      sample_strobe <= 1'b0;
      underflow     <= 1'b0;
    end else if (!enable) begin
      bit_cnt       <= '0;
      cur_smp       <= '0;
      buf_smp       <= '0;
      buf_full      <= 1'b0;
      sample_strobe <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      sample_strobe <= 1'b0;
      underflow     <= 1'b0;
      if (step) bit_cnt <= bit_cnt + BIT_W'(1);
      if (load) begin
        if (buf_full) begin
          cur_smp       <= buf_smp;
          buf_full      <= 1'b0;
          sample_strobe <= 1'b1;
        end else if (hs) begin
          cur_smp       <= pcm.pcm_in;
          sample_strobe <= 1'b1;
        end else begin
          underflow     <= 1'b1;
        end
      end else if (hs) begin
        buf_smp  <= pcm.pcm_in;
        buf_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pdm_sd_modulator_tx.sv
// Directed bench for pdm_sd_modulator_tx: reset/idle, divider timing,
// DC density table, underflow/hold, bypass and back-to-back stall.
module tb_pdm_sd_modulator_tx;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] clk_div;
  logic [2:0] gain_shift;
  logic       pdm_clk;
  logic       pdm_out;
  logic       sample_strobe;
  logic       underflow;

  pdm_sd_modulator_tx_if pcm_if();

  pdm_sd_modulator_tx #(.OSR(64), .ACC_WIDTH(24)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .clk_div       (clk_div),
    .gain_shift    (gain_shift),
    .pcm           (pcm_if),
    .pdm_clk       (pdm_clk),
    .pdm_out       (pdm_out),
    .sample_strobe (sample_strobe),
    .underflow     (underflow)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Density vectors: inputs and expected ones-count window per 64 bits.
  typedef struct {
    string              name;
    logic signed [15:0] sample;
    logic [2:0]         gshift;
    int                 lo;
    int                 hi;
  } dens_vec_t;

  dens_vec_t vecs[5];

  int checks   = 0;
  int failures = 0;

  // Observation state, updated only by tick().
  logic prev_clk, prev_out;
  bit   rise;
  int   rise_cnt, ones_cnt, strobe_cnt, uf_cnt, glitch_cnt, hi_cnt;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT event", name);
  endtask

  task automatic tick();
    @(negedge clk);
    rise = pdm_clk && !prev_clk;
    if (rise) begin
      rise_cnt++;
      ones_cnt += int'(pdm_out);
    end else if (pdm_out != prev_out) begin
      glitch_cnt++;
    end
    strobe_cnt += int'(sample_strobe);
    uf_cnt     += int'(underflow);
    hi_cnt     += int'(pdm_clk);
    prev_clk = pdm_clk;
    prev_out = pdm_out;
  endtask

  task automatic clear_counts();
    rise_cnt = 0; ones_cnt = 0; strobe_cnt = 0; uf_cnt = 0; glitch_cnt = 0; hi_cnt = 0;
  endtask

  task automatic wait_rise(input int budget, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!rise && cycles < budget);
    if (!rise) timeout("wait_rise");
  endtask

  task automatic run_rises(input int n);
    int target, budget;
    target = rise_cnt + n;
    budget = 0;
    while (rise_cnt < target && budget < 20 * n + 40) begin
      tick();
      budget++;
    end
    if (rise_cnt < target) timeout("run_rises");
  endtask

  task automatic wait_strobes(input int total);
    int budget;
    budget = 0;
    while (strobe_cnt < total && budget < 4000) begin
      tick();
      budget++;
    end
    if (strobe_cnt < total) timeout("wait_strobes");
  endtask

  // Idle for two cycles, then enable on the current falling edge.
  task automatic restart(input logic [7:0] div);
    enable = 1'b0;
    pcm_if.pcm_valid = 1'b0;
    clk_div = div;
    tick();
    tick();
    clear_counts();
    enable = 1'b1;
  endtask

  // Offer one sample; waited = cycles spent with pcm_ready low.
  task automatic send(input logic signed [15:0] v, input int budget, output int waited);
    bit ok;
    ok = 0;
    waited = 0;
    pcm_if.pcm_in = v;
    pcm_if.pcm_valid = 1'b1;
    while (!ok && waited < budget) begin
      #1;
      if (pcm_if.pcm_ready) ok = 1;
      else waited++;
      tick();
    end
    pcm_if.pcm_valid = 1'b0;
    if (!ok) timeout("send");
  endtask

  initial begin
    int cyc, w0, w1, ones_w, uf_w, st_w;

    vecs[0] = '{"zero",      16'sd0,      3'd0, 30, 34};
    vecs[1] = '{"pos_half",  16'sd16384,  3'd0, 46, 50};
    vecs[2] = '{"neg_half", -16'sd16384,  3'd0, 14, 18};
    vecs[3] = '{"pos_gs1",   16'sd16384,  3'd1, 38, 42};
    vecs[4] = '{"pos_full",  16'sd32767,  3'd0, 60, 64};

    rst = 1'b1; enable = 1'b0; clk_div = 8'd1; gain_shift = 3'd0;
    pcm_if.pcm_in = '0; pcm_if.pcm_valid = 1'b0;
    prev_clk = 1'b0; prev_out = 1'b0; rise = 0;
    clear_counts();

    // Reset state
    tick(); tick();
    check("rst_pdm_clk", pdm_clk, 0);
    check("rst_pdm_out", pdm_out, 0);
    check("rst_pcm_ready", pcm_if.pcm_ready, 0);
    check("rst_strobe", sample_strobe, 0);
    check("rst_underflow", underflow, 0);

    // Mid-stream reset with clk_div=1
    rst = 1'b0; enable = 1'b1; clk_div = 8'd1;
    pcm_if.pcm_in = 16'sd16384; pcm_if.pcm_valid = 1'b1;
    run_rises(12);
    cyc = 0;
    while (!pdm_clk && cyc < 8) begin tick(); cyc++; end
    check("pre_rst_pdm_clk_high", pdm_clk, 1);
    #2 rst = 1'b1; enable = 1'b0; pcm_if.pcm_valid = 1'b0;
    #1;
    check("midrst_pdm_clk", pdm_clk, 0);
    check("midrst_pcm_ready", pcm_if.pcm_ready, 0);
    check("midrst_outs", {pdm_out, sample_strobe, underflow}, 0);
    tick();
    rst = 1'b0;
    clear_counts();
    repeat (10) tick();
    check("idle_rises", rise_cnt, 0);
    check("idle_pcm_ready", pcm_if.pcm_ready, 0);

    // Divider: clk_div=3 gives 8-cycle period, 4 high
    restart(8'd3);
    pcm_if.pcm_in = 16'sd16384; pcm_if.pcm_valid = 1'b1;
    wait_rise(40, cyc);
    hi_cnt = 0;
    wait_rise(40, cyc);
    check("div3_period", cyc, 8);
    check("div3_high", hi_cnt, 4);
    glitch_cnt = 0;
    run_rises(20);
    check("pdm_out_only_on_rise", glitch_cnt, 0);

    // Change to clk_div=0 in the middle of a high phase
    wait_rise(40, cyc);
    clk_div = 8'd0;
    w0 = 1;
    tick();
    while (pdm_clk && w0 < 40) begin w0++; tick(); end
    check("div_change_phase", w0, 4);
    wait_rise(40, cyc);
    wait_rise(40, cyc);
    check("div0_period", cyc, 2);

    // DC density table, source always valid
    for (int i = 0; i < 5; i++) begin
      restart(8'd0);
      gain_shift = vecs[i].gshift;
      pcm_if.pcm_in = vecs[i].sample;
      pcm_if.pcm_valid = 1'b1;
      wait_strobes(4);
      ones_cnt = 0;
      run_rises(64);
      check_range({"density_", vecs[i].name}, ones_cnt, vecs[i].lo, vecs[i].hi);
      check({"no_underflow_", vecs[i].name}, uf_cnt, 0);
    end
    gain_shift = 3'd0;

    // Two samples back to back: second stalls until the first load event
    restart(8'd0);
    send(16'sd16384, 400, w0);
    send(16'sd16384, 400, w1);
    check("first_send_wait", w0, 0);
    check("second_send_stall", w1, 126);

    // Underflow / hold after the source stops
    wait_strobes(2);
    ones_cnt = 0; uf_cnt = 0; strobe_cnt = 0;
    run_rises(320);
    ones_w = ones_cnt; uf_w = uf_cnt; st_w = strobe_cnt;
    check("hold_underflows", uf_w, 5);
    check("hold_strobes", st_w, 0);
    check_range("hold_density", ones_w, 236, 244);

    // Resume streaming
    pcm_if.pcm_in = 16'sd16384; pcm_if.pcm_valid = 1'b1;
    uf_cnt = 0; strobe_cnt = 0;
    run_rises(320);
    check("resume_underflows", uf_cnt, 0);
    check("resume_strobes", strobe_cnt, 5);

    // Bypass: valid only on the load-event cycle with an empty buffer
    restart(8'd0);
    for (int c = 0; c < 126; c++) tick();
    pcm_if.pcm_in = 16'sd16384; pcm_if.pcm_valid = 1'b1;
    tick();
    pcm_if.pcm_valid = 1'b0;
    check("bypass_strobe", sample_strobe, 1);
    check("bypass_no_underflow", underflow, 0);
    check("bypass_buffer_empty", pcm_if.pcm_ready, 1);
    for (int c = 0; c < 128; c++) tick();
    check("bypass_next_load_underflow", underflow, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
